// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: checker access type and the transaction-logic arbiter states.
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'b00,
        ACCESS_READ  = 2'b01,
        ACCESS_WRITE = 2'b10,
        ACCESS_EXEC  = 2'b11
    } access_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_CHECK = 2'b01,
        ARB_RESP  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/rv_iopmp_rr_picker.sv
// Round-robin picker: first valid index at or after ptr (wrapping), as onehot and binary.
module rv_iopmp_rr_picker #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         onehot,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    int unsigned      cand;
    logic [PW-1:0]    cand_idx;

    always_comb begin
        onehot   = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(ptr) + i) % NUM_REQ;
            cand_idx = PW'(cand);
            if (!any && valid[cand_idx]) begin
                any              = 1'b1;
                onehot[cand_idx] = 1'b1;
                idx              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rv_iopmp_tl_arbiter.sv
// Round-robin arbiter sharing one transaction-logic checker between NUM_REQ requesters.
module rv_iopmp_tl_arbiter
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SID_WIDTH  = 1,
    parameter int unsigned CHECK_LAT  = 1,
    localparam int unsigned NB        = $clog2(DATA_WIDTH/8) + 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][NB-1:0]           req_num_bytes_i,
    input  logic [NUM_REQ-1:0][SID_WIDTH-1:0]    req_sid_i,
    input  access_t [NUM_REQ-1:0]                req_access_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    input  logic [NUM_REQ-1:0]                   rsp_ready_i,
    output logic                                 rsp_allow_o,
    output logic                                 tl_en_o,
    output logic [ADDR_WIDTH-1:0]                tl_addr_o,
    output logic [NB-1:0]                        tl_num_bytes_o,
    output logic [SID_WIDTH-1:0]                 tl_sid_o,
    output access_t                              tl_access_o,
    input  logic                                 tl_allow_i
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(CHECK_LAT + 1);

    arb_state_e             state;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          grant_idx;
    logic [CW-1:0]          cnt;
    logic                   allow_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [NB-1:0]          nb_q;
    logic [SID_WIDTH-1:0]   sid_q;
    access_t                access_q;

    logic [NUM_REQ-1:0]     pick_onehot;
    logic [PW-1:0]          pick_idx;
    logic                   pick_any;

    rv_iopmp_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid  (req_valid_i),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            cnt       <= '0;
            allow_q   <= 1'b0;
            addr_q    <= '0;
            nb_q      <= '0;
            sid_q     <= '0;
            access_q  <= ACCESS_NONE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state     <= ARB_CHECK;
                        grant_idx <= pick_idx;
                        cnt       <= CW'(CHECK_LAT - 1);
                        addr_q    <= req_addr_i[pick_idx];
                        nb_q      <= req_num_bytes_i[pick_idx];
                        sid_q     <= req_sid_i[pick_idx];
                        access_q  <= req_access_i[pick_idx];
                    end
                end
                ARB_CHECK: begin
                    // Verdict is only trusted on the last cycle of the checker latency window.
                    if (cnt == '0) begin
                        allow_q <= tl_allow_i;
                        state   <= ARB_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ARB_RESP: begin
                    if (rsp_ready_i[grant_idx]) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_allow_o = 1'b0;
        tl_en_o     = 1'b0;
        case (state)
            ARB_IDLE:  req_ready_o = pick_onehot;
            ARB_CHECK: tl_en_o = 1'b1;
            ARB_RESP: begin
                rsp_valid_o[grant_idx] = 1'b1;
                rsp_allow_o            = allow_q;
            end
            default: ;
        endcase
    end

    assign tl_addr_o      = addr_q;
    assign tl_num_bytes_o = nb_q;
    assign tl_sid_o       = sid_q;
    assign tl_access_o    = access_q;

endmodule

// File: tb/tb_rv_iopmp_tl_arbiter.sv
// Directed bench for rv_iopmp_tl_arbiter: 2-req/LAT1, 2-req/LAT3 and 3-req/LAT1 instances.
module tb_rv_iopmp_tl_arbiter;
    import rv_iopmp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Instance a: NUM_REQ=2, CHECK_LAT=1
    logic [1:0]        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [1:0][63:0]  a_req_addr;
    logic [1:0][3:0]   a_req_nb;
    logic [1:0][0:0]   a_req_sid;
    access_t [1:0]     a_req_access;
    logic              a_rsp_allow, a_tl_en, a_tl_allow;
    logic [63:0]       a_tl_addr;
    logic [3:0]        a_tl_nb;
    logic [0:0]        a_tl_sid;
    access_t           a_tl_access;

    // Instance b: NUM_REQ=2, CHECK_LAT=3
    logic [1:0]        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [1:0][63:0]  b_req_addr;
    logic [1:0][3:0]   b_req_nb;
    logic [1:0][0:0]   b_req_sid;
    access_t [1:0]     b_req_access;
    logic              b_rsp_allow, b_tl_en, b_tl_allow;
    logic [63:0]       b_tl_addr;
    logic [3:0]        b_tl_nb;
    logic [0:0]        b_tl_sid;
    access_t           b_tl_access;

    // Instance c: NUM_REQ=3, CHECK_LAT=1
    logic [2:0]        c_req_valid, c_req_ready, c_rsp_valid, c_rsp_ready;
    logic [2:0][63:0]  c_req_addr;
    logic [2:0][3:0]   c_req_nb;
    logic [2:0][0:0]   c_req_sid;
    access_t [2:0]     c_req_access;
    logic              c_rsp_allow, c_tl_en, c_tl_allow;
    logic [63:0]       c_tl_addr;
    logic [3:0]        c_tl_nb;
    logic [0:0]        c_tl_sid;
    access_t           c_tl_access;

    rv_iopmp_tl_arbiter #(.NUM_REQ(2), .CHECK_LAT(1)) u_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .req_addr_i(a_req_addr), .req_num_bytes_i(a_req_nb),
        .req_sid_i(a_req_sid), .req_access_i(a_req_access),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_allow_o(a_rsp_allow),
        .tl_en_o(a_tl_en), .tl_addr_o(a_tl_addr), .tl_num_bytes_o(a_tl_nb),
        .tl_sid_o(a_tl_sid), .tl_access_o(a_tl_access), .tl_allow_i(a_tl_allow)
    );

    rv_iopmp_tl_arbiter #(.NUM_REQ(2), .CHECK_LAT(3)) u_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_addr_i(b_req_addr), .req_num_bytes_i(b_req_nb),
        .req_sid_i(b_req_sid), .req_access_i(b_req_access),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_allow_o(b_rsp_allow),
        .tl_en_o(b_tl_en), .tl_addr_o(b_tl_addr), .tl_num_bytes_o(b_tl_nb),
        .tl_sid_o(b_tl_sid), .tl_access_o(b_tl_access), .tl_allow_i(b_tl_allow)
    );

    rv_iopmp_tl_arbiter #(.NUM_REQ(3), .CHECK_LAT(1)) u_c (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(c_req_valid), .req_ready_o(c_req_ready),
        .req_addr_i(c_req_addr), .req_num_bytes_i(c_req_nb),
        .req_sid_i(c_req_sid), .req_access_i(c_req_access),
        .rsp_valid_o(c_rsp_valid), .rsp_ready_i(c_rsp_ready), .rsp_allow_o(c_rsp_allow),
        .tl_en_o(c_tl_en), .tl_addr_o(c_tl_addr), .tl_num_bytes_o(c_tl_nb),
        .tl_sid_o(c_tl_sid), .tl_access_o(c_tl_access), .tl_allow_i(c_tl_allow)
    );

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_req_valid = '0; a_rsp_ready = '0; a_tl_allow = 1'b0;
        a_req_addr = '0; a_req_nb = '0; a_req_sid = '0; a_req_access = '0;
        b_req_valid = '0; b_rsp_ready = '0; b_tl_allow = 1'b0;
        b_req_addr = '0; b_req_nb = '0; b_req_sid = '0; b_req_access = '0;
        c_req_valid = '0; c_rsp_ready = '0; c_tl_allow = 1'b0;
        c_req_addr = '0; c_req_nb = '0; c_req_sid = '0; c_req_access = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++; if (a_req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready got=%b exp=00", a_req_ready); end
        tests_run++; if (a_rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid got=%b exp=00", a_rsp_valid); end
        tests_run++; if (a_tl_en !== 1'b0) begin tests_failed++; $display("FAIL reset_tl_en got=%b exp=0", a_tl_en); end
        tests_run++; if (a_tl_addr !== 64'h0) begin tests_failed++; $display("FAIL reset_tl_addr got=%h exp=0", a_tl_addr); end
        tests_run++; if (a_rsp_allow !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_allow got=%b exp=0", a_rsp_allow); end
        next();
        rst = 1'b0;
        // Mid-CHECK reset drops the in-flight check.
        a_req_valid = 2'b01; a_req_addr[0] = 64'h0000_0000_0000_1234; a_req_nb[0] = 4'd4;
        a_req_access[0] = ACCESS_WRITE; a_tl_allow = 1'b1; a_rsp_ready = 2'b11;
        @(negedge clk);
        tests_run++; if (a_req_ready !== 2'b01) begin tests_failed++; $display("FAIL rstmid_accept got=%b exp=01", a_req_ready); end
        next();
        a_req_valid = 2'b00;
        @(negedge clk);
        tests_run++; if (a_tl_en !== 1'b1) begin tests_failed++; $display("FAIL rstmid_in_check got=%b exp=1", a_tl_en); end
        rst = 1'b1;
        #1;
        tests_run++; if (a_tl_en !== 1'b0) begin tests_failed++; $display("FAIL rstmid_tl_en got=%b exp=0", a_tl_en); end
        tests_run++; if (a_tl_addr !== 64'h0) begin tests_failed++; $display("FAIL rstmid_tl_addr got=%h exp=0", a_tl_addr); end
        tests_run++; if (a_tl_access !== ACCESS_NONE) begin tests_failed++; $display("FAIL rstmid_tl_access got=%0d exp=0", a_tl_access); end
        next();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++; if (a_rsp_valid !== 2'b00 || a_tl_en !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_rsp cyc=%0d rsp_valid=%b tl_en=%b exp=00/0", i, a_rsp_valid, a_tl_en); end
        end
    endtask

    task automatic test_single();
        do_reset();
        a_req_valid = 2'b01; a_req_addr[0] = 64'h0000_0000_8000_1000; a_req_nb[0] = 4'd8;
        a_req_sid[0] = 1'b0; a_req_access[0] = ACCESS_READ; a_tl_allow = 1'b1; a_rsp_ready = 2'b01;
        @(negedge clk);
        tests_run++; if (a_req_ready !== 2'b01) begin tests_failed++; $display("FAIL single_ready got=%b exp=01", a_req_ready); end
        tests_run++; if (a_tl_en !== 1'b0) begin tests_failed++; $display("FAIL single_en_c0 got=%b exp=0", a_tl_en); end
        next();
        a_req_valid = 2'b00;
        @(negedge clk);
        tests_run++; if (a_tl_en !== 1'b1) begin tests_failed++; $display("FAIL single_en_c1 got=%b exp=1", a_tl_en); end
        tests_run++; if (a_tl_addr !== 64'h0000_0000_8000_1000) begin tests_failed++; $display("FAIL single_addr got=%h exp=80001000", a_tl_addr); end
        tests_run++; if (a_tl_nb !== 4'd8) begin tests_failed++; $display("FAIL single_nb got=%0d exp=8", a_tl_nb); end
        tests_run++; if (a_tl_access !== ACCESS_READ) begin tests_failed++; $display("FAIL single_access got=%0d exp=1", a_tl_access); end
        tests_run++; if (a_rsp_valid !== 2'b00 || a_req_ready !== 2'b00) begin tests_failed++; $display("FAIL single_quiet_c1 rsp=%b ready=%b exp=00/00", a_rsp_valid, a_req_ready); end
        next();
        a_tl_allow = 1'b0;
        @(negedge clk);
        tests_run++; if (a_rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL single_rsp_valid got=%b exp=01", a_rsp_valid); end
        tests_run++; if (a_rsp_allow !== 1'b1) begin tests_failed++; $display("FAIL single_allow got=%b exp=1", a_rsp_allow); end
        tests_run++; if (a_tl_en !== 1'b0) begin tests_failed++; $display("FAIL single_en_c2 got=%b exp=0", a_tl_en); end
        @(negedge clk);
        tests_run++; if (a_rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL single_rsp_done got=%b exp=00", a_rsp_valid); end
        tests_run++; if (a_tl_addr !== 64'h0000_0000_8000_1000) begin tests_failed++; $display("FAIL single_addr_hold got=%h exp=80001000", a_tl_addr); end
    endtask

    task automatic test_both_valid();
        logic [1:0]  exp_g;
        logic [63:0] exp_addr;
        bit          found;
        do_reset();
        a_req_addr[0] = 64'h0000_0000_1000_0000; a_req_nb[0] = 4'd8; a_req_sid[0] = 1'b0; a_req_access[0] = ACCESS_READ;
        a_req_addr[1] = 64'h0000_0000_2000_0040; a_req_nb[1] = 4'd2; a_req_sid[1] = 1'b1; a_req_access[1] = ACCESS_WRITE;
        a_req_valid = 2'b11; a_rsp_ready = 2'b11; a_tl_allow = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_g    = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 64'h0000_0000_1000_0000 : 64'h0000_0000_2000_0040;
            found = 1'b0;
            for (int n = 0; n < 8 && !found; n++) begin
                @(negedge clk);
                if (a_req_ready !== 2'b00) found = 1'b1;
            end
            tests_run++;
            if (!found) begin
                tests_failed++; $display("FAIL rr_grant_timeout k=%0d got=none exp=%b", k, exp_g);
            end else begin
                if (a_req_ready !== exp_g) begin tests_failed++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, a_req_ready, exp_g); end
                @(negedge clk);
                tests_run++; if (a_tl_en !== 1'b1 || a_tl_addr !== exp_addr) begin tests_failed++; $display("FAIL rr_tl k=%0d en=%b addr=%h exp=1/%h", k, a_tl_en, a_tl_addr, exp_addr); end
                tests_run++; if (a_tl_sid !== exp_g[1:1]) begin tests_failed++; $display("FAIL rr_sid k=%0d got=%b exp=%b", k, a_tl_sid, exp_g[1]); end
                @(negedge clk);
                tests_run++; if (a_rsp_valid !== exp_g || a_rsp_allow !== 1'b0) begin tests_failed++; $display("FAIL rr_rsp k=%0d valid=%b allow=%b exp=%b/0", k, a_rsp_valid, a_rsp_allow, exp_g); end
            end
        end
        a_req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        do_reset();
        a_req_addr[0] = 64'h0000_0000_3000_0000; a_req_addr[1] = 64'h0000_0000_4000_0000;
        a_req_valid = 2'b11; a_rsp_ready = 2'b10; a_tl_allow = 1'b1;
        @(negedge clk);
        tests_run++; if (a_req_ready !== 2'b01) begin tests_failed++; $display("FAIL bp_grant got=%b exp=01", a_req_ready); end
        next();
        next();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++; if (a_rsp_valid !== 2'b01 || a_req_ready !== 2'b00 || a_rsp_allow !== 1'b1) begin
                tests_failed++; $display("FAIL bp_hold cyc=%0d rsp=%b ready=%b allow=%b exp=01/00/1", i, a_rsp_valid, a_req_ready, a_rsp_allow);
            end
            next();
        end
        a_rsp_ready = 2'b11;
        @(negedge clk);
        tests_run++; if (a_rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL bp_release got=%b exp=01", a_rsp_valid); end
        next();
        @(negedge clk);
        tests_run++; if (a_req_ready !== 2'b10) begin tests_failed++; $display("FAIL bp_req1_next got=%b exp=10", a_req_ready); end
        next();
        a_req_valid = 2'b00;
    endtask

    task automatic test_check_lat3();
        logic [2:0] allow_seq [2];
        logic       exp_allow [2];
        logic [63:0] addr_v [2];
        allow_seq[0] = 3'b101; exp_allow[0] = 1'b1; addr_v[0] = 64'h0000_0000_8000_2000;
        allow_seq[1] = 3'b011; exp_allow[1] = 1'b0; addr_v[1] = 64'h0000_0000_8000_3000;
        do_reset();
        b_rsp_ready = 2'b01;
        for (int r = 0; r < 2; r++) begin
            b_req_valid = 2'b01; b_req_addr[0] = addr_v[r]; b_req_nb[0] = 4'd4; b_req_access[0] = ACCESS_EXEC;
            @(negedge clk);
            tests_run++; if (b_req_ready !== 2'b01) begin tests_failed++; $display("FAIL lat3_accept r=%0d got=%b exp=01", r, b_req_ready); end
            for (int c = 0; c < 3; c++) begin
                next();
                b_req_valid = 2'b00;
                b_req_addr[0] = 64'hDEAD_BEEF_0000_0000;
                b_req_access[0] = ACCESS_NONE;
                b_tl_allow = allow_seq[r][c];
                @(negedge clk);
                tests_run++; if (b_tl_en !== 1'b1 || b_tl_addr !== addr_v[r] || b_tl_access !== ACCESS_EXEC || b_tl_nb !== 4'd4) begin
                    tests_failed++; $display("FAIL lat3_stable r=%0d c=%0d en=%b addr=%h acc=%0d nb=%0d exp=1/%h/3/4", r, c, b_tl_en, b_tl_addr, b_tl_access, b_tl_nb, addr_v[r]);
                end
                tests_run++; if (b_rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL lat3_early_rsp r=%0d c=%0d got=%b exp=00", r, c, b_rsp_valid); end
            end
            next();
            b_tl_allow = ~exp_allow[r];
            @(negedge clk);
            tests_run++; if (b_rsp_valid !== 2'b01 || b_rsp_allow !== exp_allow[r] || b_tl_en !== 1'b0) begin
                tests_failed++; $display("FAIL lat3_rsp r=%0d valid=%b allow=%b en=%b exp=01/%b/0", r, b_rsp_valid, b_rsp_allow, b_tl_en, exp_allow[r]);
            end
            next();
        end
    endtask

    task automatic test_three_wrap();
        do_reset();
        c_req_addr[0] = 64'h0000_0000_0000_0A00; c_req_addr[1] = 64'h0000_0000_0000_0B00; c_req_addr[2] = 64'h0000_0000_0000_0C00;
        c_rsp_ready = 3'b111; c_tl_allow = 1'b1;
        c_req_valid = 3'b010;
        @(negedge clk);
        tests_run++; if (c_req_ready !== 3'b010) begin tests_failed++; $display("FAIL wrap_first got=%b exp=010", c_req_ready); end
        next();
        c_req_valid = 3'b000;
        next();
        @(negedge clk);
        tests_run++; if (c_rsp_valid !== 3'b010) begin tests_failed++; $display("FAIL wrap_rsp1 got=%b exp=010", c_rsp_valid); end
        next();
        c_req_valid = 3'b011;
        @(negedge clk);
        tests_run++; if (c_req_ready !== 3'b001) begin tests_failed++; $display("FAIL wrap_grant0 got=%b exp=001", c_req_ready); end
        next();
        @(negedge clk);
        tests_run++; if (c_tl_addr !== 64'h0000_0000_0000_0A00) begin tests_failed++; $display("FAIL wrap_addr got=%h exp=a00", c_tl_addr); end
        next();
        @(negedge clk);
        tests_run++; if (c_rsp_valid !== 3'b001) begin tests_failed++; $display("FAIL wrap_rsp0 got=%b exp=001", c_rsp_valid); end
        next();
        @(negedge clk);
        tests_run++; if (c_req_ready !== 3'b010) begin tests_failed++; $display("FAIL wrap_ptr1 got=%b exp=010", c_req_ready); end
        next();
        c_req_valid = 3'b000;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_both_valid();
        test_backpressure();
        test_check_lat3();
        test_three_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
